// File: rtl/regfile_seq_ctrl_pkg.sv
// rtl/regfile_seq_ctrl_pkg.sv - shared opcodes, state encoding and width defaults
package regfile_seq_ctrl_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 3;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_COPY  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_SUM   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    SCAN = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - command-driven sequencer for the 8x8 register file
module regfile_seq_ctrl
  import regfile_seq_ctrl_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AW-1:0]     cmd_rd,
  input  logic [AW-1:0]     cmd_rs,
  input  logic [DW-1:0]     cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW+AW-1:0]  rsp_data,
  output logic              busy,
  output logic              rf_wen,
  output logic [AW-1:0]     rf_wsel,
  output logic [DW-1:0]     rf_d,
  output logic [AW-1:0]     rf_rsel,
  input  logic [DW-1:0]     rf_q
);

  state_t               state, state_nxt;
  op_t                  op_q;
  logic [AW-1:0]        rd_q, rs_q, idx;
  logic [DW-1:0]        imm_q;
  logic [DW+AW-1:0]     acc, result;
  logic [DW+AW-1:0]     q_ext;
  logic                 last_idx;

  assign q_ext    = {{AW{1'b0}}, rf_q};
  assign last_idx = &idx;

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      op_q   <= OP_WRITE;
      rd_q   <= '0;
      rs_q   <= '0;
      imm_q  <= '0;
      idx    <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= op_t'(cmd_op);
            rd_q  <= cmd_rd;
            rs_q  <= cmd_rs;
            imm_q <= cmd_imm;
            idx   <= '0;
            acc   <= '0;
          end
        end
        EXEC: begin
          result <= (op_q == OP_COPY) ? q_ext : {{AW{1'b0}}, imm_q};
        end
        SCAN: begin
          if (op_q == OP_SUM) acc <= acc + q_ext;
          idx <= idx + 1'b1;
          // Fold the final read into the result so RESP need not look at acc.
          if (last_idx) result <= (op_q == OP_SUM) ? acc + q_ext : '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid)
              state_nxt = (cmd_op == OP_WRITE || cmd_op == OP_COPY) ? EXEC : SCAN;
      EXEC: state_nxt = RESP;
      SCAN: if (last_idx) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is forced low while clr is asserted, so no write leaks into a reset cycle.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rf_wen    = 1'b0;
    rf_wsel   = '0;
    rf_d      = '0;
    rf_rsel   = '0;
    if (!clr) begin
      cmd_ready = (state == IDLE);
      busy      = (state != IDLE);
      case (state)
        EXEC: begin
          rf_wen  = 1'b1;
          rf_wsel = rd_q;
          if (op_q == OP_COPY) begin
            rf_rsel = rs_q;
            rf_d    = rf_q;
          end else begin
            rf_d    = imm_q;
          end
        end
        SCAN: begin
          if (op_q == OP_CLEAR) begin
            rf_wen  = 1'b1;
            rf_wsel = idx;
          end else begin
            rf_rsel = idx;
          end
        end
        RESP: begin
          rsp_valid = 1'b1;
          rsp_data  = result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb/tb_regfile_seq_ctrl.sv - self-checking bench with a command-level register file model
module tb_regfile_seq_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          clr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_rs;
  logic [DW-1:0] cmd_imm;
  logic          rsp_valid, rsp_ready;
  logic [DW+AW-1:0] rsp_data;
  logic          busy;
  logic          rf_wen;
  logic [AW-1:0] rf_wsel, rf_rsel;
  logic [DW-1:0] rf_d, rf_q;

  logic [DW-1:0] rf_mem [8];
  logic [DW-1:0] ref_mem [8];

  int tests_run = 0;
  int fails = 0;

  int obs_lat;
  logic [DW+AW-1:0] obs_data;
  int obs_wsel[$];
  int obs_rsel[$];
  int obs_d_nonzero;
  int obs_ready_after;

  always #5 clk = ~clk;

  // Register file beside the controller: combinational read, write on the rising edge.
  assign rf_q = rf_mem[rf_rsel];
  always @(posedge clk) if (rf_wen) rf_mem[rf_wsel] <= rf_d;

  regfile_seq_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy),
    .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_d(rf_d), .rf_rsel(rf_rsel), .rf_q(rf_q)
  );

  function automatic logic [DW+AW-1:0] model_exec(input int op, input int rd, input int rs,
                                                   input logic [DW-1:0] imm);
    int sum;
    case (op)
      0: begin ref_mem[rd] = imm; return 11'(imm); end
      1: begin ref_mem[rd] = ref_mem[rs]; return 11'(ref_mem[rd]); end
      2: begin for (int i = 0; i < 8; i++) ref_mem[i] = '0; return '0; end
      default: begin
        sum = 0;
        for (int i = 0; i < 8; i++) sum += ref_mem[i];
        return 11'(sum);
      end
    endcase
  endfunction

  // Issues one command and records what the bus did until the response handshake.
  task automatic run_cmd(input int op, input int rd, input int rs, input logic [DW-1:0] imm);
    int guard;
    obs_wsel.delete();
    obs_rsel.delete();
    obs_d_nonzero = 0;
    obs_lat = -1;
    obs_data = '0;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 40) begin @(negedge clk); guard++; end
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_rd = 3'(rd); cmd_rs = 3'(rs); cmd_imm = imm;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_rd = 3'($urandom); cmd_rs = 3'($urandom); cmd_imm = 8'($urandom);
      end
      if (rsp_valid) begin obs_lat = c; obs_data = rsp_data; break; end
      if (rf_wen) begin
        obs_wsel.push_back(int'(rf_wsel));
        if (rf_d != 0 && op == 2) obs_d_nonzero++;
      end else begin
        obs_rsel.push_back(int'(rf_rsel));
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    obs_ready_after = int'(cmd_ready);
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rf_mem[i] !== ref_mem[i]) begin
        fails++;
        $display("FAIL %s r%0d: got %h expected %h", name, i, rf_mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_imm = '0;
    for (int i = 0; i < 8; i++) begin rf_mem[i] = 8'(i * 17 + 1); ref_mem[i] = 8'(i * 17 + 1); end
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({cmd_ready, busy, rsp_valid, rf_wen, rf_wsel, rf_d, rf_rsel, rsp_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b rv=%b wen=%b rsp=%h expected all 0",
               cmd_ready, busy, rsp_valid, rf_wen, rsp_data);
    end
    cmd_valid = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rf_wen !== 1'b0 || rsp_data !== '0) begin
      fails++;
      $display("FAIL reset_release: got rdy=%b busy=%b rv=%b wen=%b expected rdy=1 rest 0",
               cmd_ready, busy, rsp_valid, rf_wen);
    end
  endtask

  task automatic test_write();
    logic [DW+AW-1:0] exp;
    exp = model_exec(0, 3, 0, 8'hA5);
    run_cmd(0, 3, 0, 8'hA5);
    tests_run++;
    if (obs_lat !== 2 || obs_data !== exp) begin
      fails++;
      $display("FAIL write_rsp: got lat=%0d data=%h expected lat=2 data=%h", obs_lat, obs_data, exp);
    end
    tests_run++;
    if (obs_wsel.size() != 1 || (obs_wsel.size() == 1 && obs_wsel[0] != 3)) begin
      fails++;
      $display("FAIL write_wen: got %0d write cycles expected 1 to r3", obs_wsel.size());
    end
    tests_run++;
    if (obs_ready_after !== 1) begin
      fails++;
      $display("FAIL write_ready_after: got %0d expected 1", obs_ready_after);
    end
    check_mem("write_mem");
  endtask

  task automatic test_sum_full();
    logic [DW+AW-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      void'(model_exec(0, i, 0, 8'hFF));
      run_cmd(0, i, 0, 8'hFF);
    end
    exp = model_exec(3, 0, 0, 8'h00);
    run_cmd(3, 0, 0, 8'h00);
    tests_run++;
    if (obs_lat !== 9 || obs_data !== 11'd2040 || exp !== 11'd2040) begin
      fails++;
      $display("FAIL sum_full: got lat=%0d data=%0d expected lat=9 data=2040", obs_lat, obs_data);
    end
    tests_run++;
    if (obs_wsel.size() != 0 || obs_rsel.size() != 8) begin
      fails++;
      $display("FAIL sum_cycles: got writes=%0d reads=%0d expected 0 and 8", obs_wsel.size(), obs_rsel.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (obs_rsel[i] != i) begin
          fails++;
          $display("FAIL sum_rsel[%0d]: got %0d expected %0d", i, obs_rsel[i], i);
        end
      end
    end
  endtask

  task automatic test_copy();
    logic [DW+AW-1:0] exp;
    void'(model_exec(0, 2, 0, 8'h3C));
    run_cmd(0, 2, 0, 8'h3C);
    exp = model_exec(1, 6, 2, 8'h00);
    run_cmd(1, 6, 2, 8'h00);
    tests_run++;
    if (obs_lat !== 2 || obs_data !== 11'h03C || exp !== 11'h03C) begin
      fails++;
      $display("FAIL copy_rsp: got lat=%0d data=%h expected lat=2 data=03c", obs_lat, obs_data);
    end
    exp = model_exec(1, 6, 6, 8'h00);
    run_cmd(1, 6, 6, 8'h00);
    tests_run++;
    if (obs_data !== exp || rf_mem[6] !== 8'h3C) begin
      fails++;
      $display("FAIL copy_self: got data=%h r6=%h expected data=%h r6=3c", obs_data, rf_mem[6], exp);
    end
    check_mem("copy_mem");
  endtask

  task automatic test_clear();
    logic [DW+AW-1:0] exp;
    logic [DW-1:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom_range(1, 255));
      void'(model_exec(0, i, 0, v));
      run_cmd(0, i, 0, v);
    end
    exp = model_exec(2, 0, 0, 8'h00);
    run_cmd(2, 0, 0, 8'h00);
    tests_run++;
    if (obs_lat !== 9 || obs_data !== exp || obs_d_nonzero != 0 || obs_wsel.size() != 8) begin
      fails++;
      $display("FAIL clear_rsp: got lat=%0d data=%h nonzero_d=%0d writes=%0d expected 9/0/0/8",
               obs_lat, obs_data, obs_d_nonzero, obs_wsel.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (obs_wsel[i] != i) begin
          fails++;
          $display("FAIL clear_wsel[%0d]: got %0d expected %0d", i, obs_wsel[i], i);
        end
      end
    end
    exp = model_exec(3, 0, 0, 8'h00);
    run_cmd(3, 0, 0, 8'h00);
    tests_run++;
    if (obs_data !== exp || exp !== '0) begin
      fails++;
      $display("FAIL clear_then_sum: got %h expected 0", obs_data);
    end
    check_mem("clear_mem");
  endtask

  task automatic test_resp_hold();
    logic [DW+AW-1:0] exp, held;
    int guard;
    exp = model_exec(0, 5, 0, 8'h5A);
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rd = 3'd5; cmd_imm = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    held = rsp_data;
    tests_run++;
    if (!rsp_valid || held !== exp) begin
      fails++;
      $display("FAIL hold_first: got rv=%b data=%h expected rv=1 data=%h", rsp_valid, held, exp);
    end
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_rd = 3'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0 || rf_wen !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle%0d: got rv=%b data=%h rdy=%b wen=%b expected 1/%h/0/0",
                 c, rsp_valid, rsp_data, cmd_ready, rf_wen, exp);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    tests_run++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: got rdy=%b rv=%b busy=%b expected 1/0/0", cmd_ready, rsp_valid, busy);
    end
    check_mem("hold_mem");
  endtask

  task automatic test_reset_mid_clear();
    logic [DW-1:0] v;
    int seen_rsp;
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom_range(1, 255));
      void'(model_exec(0, i, 0, v));
      run_cmd(0, i, 0, v);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2;
    @(posedge clk);
    // Scan index k is presented in cycle k+1, so index 4 is cycle 5.
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    clr = 1'b1;
    #1;
    tests_run++;
    if (rf_wen !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midclr_outputs: got wen=%b rdy=%b busy=%b expected 0", rf_wen, cmd_ready, busy);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL midclr_ready: got %b expected 1", cmd_ready);
    end
    seen_rsp = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    tests_run++;
    if (seen_rsp != 0) begin
      fails++;
      $display("FAIL midclr_no_rsp: got %0d response cycles expected 0", seen_rsp);
    end
    check_mem("midclr_mem");
  endtask

  task automatic test_random();
    int op, rd, rs;
    logic [DW-1:0] imm;
    logic [DW+AW-1:0] exp;
    for (int n = 0; n < 40; n++) begin
      op = (n % 10 == 9) ? $urandom_range(2, 3) : $urandom_range(0, 3);
      if (op == 2 && $urandom_range(0, 3) != 0) op = 0;
      rd = $urandom_range(0, 7);
      rs = $urandom_range(0, 7);
      imm = 8'($urandom);
      exp = model_exec(op, rd, rs, imm);
      run_cmd(op, rd, rs, imm);
      tests_run++;
      if (obs_data !== exp || obs_lat !== ((op < 2) ? 2 : 9)) begin
        fails++;
        $display("FAIL random%0d op%0d: got data=%h lat=%0d expected data=%h lat=%0d",
                 n, op, obs_data, obs_lat, exp, (op < 2) ? 2 : 9);
      end
    end
    check_mem("random_mem");
  endtask

  initial begin
    test_reset();
    test_write();
    test_sum_full();
    test_copy();
    test_clear();
    test_resp_hold();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
